// File: rtl/sram_pkg.sv
// Shared constants and helpers for the single-port SRAM responder.
// Holds the default memory geometry, the address range check and the byte-lane merge rule.
package sram_pkg;

  localparam int unsigned DEFAULT_DEPTH_LOG2 = 12;
  localparam logic [31:0] DEFAULT_BASE_ADDR  = 32'h1c00_0000;

  // The limit is one bit wider than the offset so a 2^30-word memory still has a representable bound.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned depth_log2);
    logic [31:0] off;
    logic [32:0] limit;
    off   = addr - base;
    limit = 33'd4 << depth_log2;
    return {1'b0, off} < limit;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  we);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_byte_bank.sv
// One byte lane of the responder: 2^DEPTH_LOG2 x 8 read-first storage.
// Read data is registered one cycle after rd_en and held while rd_en is low; there is no stall.
module sram_byte_bank
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  logic [7:0] mem [2**DEPTH_LOG2];
  logic [7:0] rd_q;
  logic [7:0] rd_d;

  // The old word is sampled on the same edge that writes the new one, giving read-first behaviour.
  always_comb begin
    rd_d = rd_q;
    if (rd_en) rd_d = mem[idx];
  end

  always_ff @(posedge clk) begin
    rd_q <= rd_d;
    if (wr_en) mem[idx] <= wdata;
  end

  assign rdata = rd_q;

endmodule

// File: rtl/sram_responder.sv
// Fixed one-cycle-latency SRAM responder with out-of-range detection; accepts one access per cycle,
// never back-pressures. Out-of-range accesses read as zero, never write, and bump a sticky error counter.
module sram_responder
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  input  logic        clr_err,
  output logic        oor_err,
  output logic [15:0] oor_cnt
);

  logic                  in_rng;
  logic                  acc_ok;
  logic                  acc_oor;
  logic [DEPTH_LOG2-1:0] idx;
  logic [3:0]            lane_we;
  logic [31:0]           bank_rdata;

  logic                  zero_q, zero_d;
  logic                  oor_err_q, oor_err_d;
  logic [15:0]           oor_cnt_q, oor_cnt_d;

  assign in_rng  = addr_in_range(sram_addr, BASE_ADDR, DEPTH_LOG2);
  assign acc_ok  = sram_en & in_rng;
  assign acc_oor = sram_en & ~in_rng;
  assign idx     = DEPTH_LOG2'((sram_addr - BASE_ADDR) >> 2);
  assign lane_we = acc_ok ? sram_we : 4'b0000;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    sram_byte_bank #(
      .DEPTH_LOG2(DEPTH_LOG2)
    ) u_bank (
      .clk   (clk),
      .rd_en (acc_ok),
      .wr_en (lane_we[i]),
      .idx   (idx),
      .wdata (sram_wdata[8*i +: 8]),
      .rdata (bank_rdata[8*i +: 8])
    );
  end

  // zero_q masks the bank output: it covers out-of-range reads and the post-reset state,
  // and only changes on enabled accesses so the held read data survives idle cycles.
  always_comb begin
    zero_d    = zero_q;
    oor_err_d = oor_err_q;
    oor_cnt_d = oor_cnt_q;
    if (sram_en) zero_d = ~in_rng;
    if (clr_err) begin
      oor_err_d = 1'b0;
      oor_cnt_d = 16'h0000;
    end
    if (acc_oor) begin
      oor_err_d = 1'b1;
      if (clr_err)                  oor_cnt_d = 16'h0001;
      else if (oor_cnt_q != 16'hFFFF) oor_cnt_d = oor_cnt_q + 16'h0001;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_q    <= 1'b1;
      oor_err_q <= 1'b0;
      oor_cnt_q <= 16'h0000;
    end else begin
      zero_q    <= zero_d;
      oor_err_q <= oor_err_d;
      oor_cnt_q <= oor_cnt_d;
    end
  end

  assign sram_rdata = zero_q ? 32'h0000_0000 : bank_rdata;
  assign oor_err    = oor_err_q;
  assign oor_cnt    = oor_cnt_q;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed vector table, random traffic against a word-level model,
// asynchronous reset mid-access and counter saturation.
`timescale 1ns/1ps
module tb_sram_responder;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sram_en = 1'b0;
  logic [3:0]  sram_we = 4'h0;
  logic [31:0] sram_addr = 32'h0;
  logic [31:0] sram_wdata = 32'h0;
  logic [31:0] sram_rdata;
  logic        clr_err = 1'b0;
  logic        oor_err;
  logic [15:0] oor_cnt;

  sram_responder #(.DEPTH_LOG2(12), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .clr_err    (clr_err),
    .oor_err    (oor_err),
    .oor_cnt    (oor_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [DEPTH];
  logic [31:0] m_rd;
  logic        m_err;
  int          m_cnt;

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] off;
    logic [31:0] wd;
    logic        clr;
    logic [31:0] rd;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [21];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // One clock of stimulus; the model is advanced from the access rules, then outputs are sampled #1 after the edge.
  task automatic cyc(input logic en, input logic [3:0] we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic clr, input bit chk);
    logic [31:0] off;
    bit          inr;
    int          w;
    sram_en = en; sram_we = we; sram_addr = addr; sram_wdata = wd; clr_err = clr;
    @(posedge clk);
    off = addr - BASE;
    inr = off < 32'(4 * DEPTH);
    w   = int'(off >> 2);
    if (en) begin
      if (inr) begin
        m_rd = mdl[w];
        for (int b = 0; b < 4; b++)
          if (we[b]) mdl[w][8*b +: 8] = wd[8*b +: 8];
      end else begin
        m_rd = 32'h0;
      end
    end
    if (en && !inr) begin
      m_err = 1'b1;
      m_cnt = clr ? 1 : (m_cnt < 65535 ? m_cnt + 1 : 65535);
    end else if (clr) begin
      m_err = 1'b0;
      m_cnt = 0;
    end
    #1;
    if (chk) begin
      check("model_rdata", sram_rdata, m_rd);
      check("model_err", {31'b0, oor_err}, {31'b0, m_err});
      check("model_cnt", {16'b0, oor_cnt}, 32'(m_cnt));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'hC0DE_0004, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h1234_5678, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 4'h5, 32'h0000_0010, 32'hAABB_CCDD, 1'b0, 32'h1234_5678, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h12BB_56DD, 1'b0, 16'd0};
    tbl[4]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hFFFF_FFFF, 1'b0, 32'h12BB_56DD, 1'b0, 16'd0};
    tbl[5]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 16'd0};
    tbl[6]  = '{1'b1, 4'h0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 16'd1};
    tbl[7]  = '{1'b1, 4'hF, 32'h0000_4000, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b1, 16'd2};
    tbl[8]  = '{1'b1, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hC0DE_0000, 1'b1, 16'd2};
    tbl[9]  = '{1'b0, 4'hF, 32'hFFFF_FFFC, 32'h1111_1111, 1'b0, 32'hC0DE_0000, 1'b1, 16'd2};
    tbl[10] = '{1'b0, 4'h0, 32'h0000_0000, 32'h2222_2222, 1'b0, 32'hC0DE_0000, 1'b1, 16'd2};
    tbl[11] = '{1'b0, 4'hA, 32'h0000_0000, 32'h3333_3333, 1'b0, 32'hC0DE_0000, 1'b1, 16'd2};
    tbl[12] = '{1'b0, 4'h5, 32'h0000_0000, 32'h4444_4444, 1'b0, 32'hC0DE_0000, 1'b1, 16'd2};
    tbl[13] = '{1'b0, 4'hF, 32'h0000_0000, 32'h5555_5555, 1'b0, 32'hC0DE_0000, 1'b1, 16'd2};
    tbl[14] = '{1'b1, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hC0DE_0000, 1'b1, 16'd2};
    tbl[15] = '{1'b1, 4'hF, 32'h0000_3FFC, 32'h0BAD_F00D, 1'b0, 32'hC0DE_0FFF, 1'b1, 16'd2};
    tbl[16] = '{1'b1, 4'h0, 32'h0000_3FFC, 32'h0000_0000, 1'b0, 32'h0BAD_F00D, 1'b1, 16'd2};
    tbl[17] = '{1'b1, 4'h3, 32'hFFFF_FFFC, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 16'd1};
    tbl[18] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 16'd0};
    tbl[19] = '{1'b1, 4'h0, 32'h0000_3FFF, 32'h0000_0000, 1'b0, 32'h0BAD_F00D, 1'b0, 16'd0};
    tbl[20] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b0, 16'd0};

    m_rd = 32'h0; m_err = 1'b0; m_cnt = 0;

    // Reset state, sampled while reset is held and again after release.
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata", sram_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_err", {31'b0, oor_err}, 32'h0);
    check("reset_cnt", {16'b0, oor_cnt}, 32'h0);
    check("reset_rdata_after", sram_rdata, 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, 4'hF, BASE + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b0, 1'b0);

    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].en, tbl[i].we, BASE + tbl[i].off, tbl[i].wd, tbl[i].clr, 1'b0);
      check($sformatf("vec%0d_rdata", i), sram_rdata, tbl[i].rd);
      check($sformatf("vec%0d_err", i), {31'b0, oor_err}, {31'b0, tbl[i].err});
      check($sformatf("vec%0d_cnt", i), {16'b0, oor_cnt}, {16'b0, tbl[i].cnt});
    end

    for (int i = 0; i < 2000; i++) begin
      logic [31:0] off;
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 85)      off = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(0, 3);
      else if (r < 93) off = 32'hFFFF_FFFC - ($urandom_range(0, 255) << 2);
      else             off = 32'h0000_4000 + $urandom_range(0, 32'h00FF_FFFF);
      cyc($urandom_range(0, 9) < 8, 4'($urandom_range(0, 15)), BASE + off, $urandom,
          $urandom_range(0, 19) == 0, 1'b1);
    end

    // Asynchronous reset arriving mid-cycle during a read.
    cyc(1'b1, 4'h0, BASE + 32'h10, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 4'h0, BASE - 32'h8, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 4'h0, BASE + 32'h10, 32'h0, 1'b0, 1'b1);
    sram_en = 1'b1; sram_we = 4'h0; sram_addr = BASE + 32'h3FFC;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_rdata", sram_rdata, 32'h0);
    check("async_rst_err", {31'b0, oor_err}, 32'h0);
    check("async_rst_cnt", {16'b0, oor_cnt}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_rd = 32'h0; m_err = 1'b0; m_cnt = 0;
    cyc(1'b1, 4'h0, BASE + 32'h10, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 4'h0, BASE + 32'h3FFC, 32'h0, 1'b0, 1'b1);

    // Counter saturation; the first access also clears, so the count restarts at 1.
    for (int i = 0; i < 65540; i++) begin
      cyc(1'b1, 4'hF, BASE + 32'h4000 + 32'(4 * (i % 16)), 32'h5A5A_5A5A, i == 0,
          i >= 65533);
    end
    check("sat_cnt", {16'b0, oor_cnt}, 32'h0000_FFFF);
    check("sat_err", {31'b0, oor_err}, 32'h1);
    cyc(1'b0, 4'h0, BASE, 32'h0, 1'b1, 1'b1);
    cyc(1'b1, 4'h0, BASE + 32'h3FFC, 32'h0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
# sram_responder

Single-port synchronous SRAM responder that sits on the far side of the CPU core's `inst_sram_*` / `data_sram_*` ports. It accepts enable, byte-write-enable, address and write data, and returns read data exactly one cycle later, matching the core's fixed-latency fetch and load path. One instance serves instruction fetch and a second serves data. Each instance also flags out-of-range accesses for bring-up debug.

## Interface
Parameters:
- `DEPTH_LOG2`, 12: memory holds 2^DEPTH_LOG2 32-bit words.
- `BASE_ADDR`, 32'h1c00_0000: byte address of word 0. Must be 4-byte aligned.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `sram_en`, in, 1: access request this cycle.
- `sram_we`, in, 4: byte write enables. Bit i covers `sram_wdata[8i+7:8i]`.
- `sram_addr`, in, 32: byte address. Bits [1:0] are ignored.
- `sram_wdata`, in, 32: write data.
- `sram_rdata`, out, 32: read data, registered.
- `clr_err`, in, 1: clears the error status.
- `oor_err`, out, 1: sticky out-of-range flag.
- `oor_cnt`, out, 16: saturating count of out-of-range accesses.

## Operation
- Offset: `off = sram_addr - BASE_ADDR`, 32-bit modulo arithmetic.
- In range: `off < 4*2^DEPTH_LOG2`, compared as unsigned. Addresses below the base wrap to large values and are therefore out of range.
- Word index: `off[DEPTH_LOG2+1:2]`.
- Every cycle with `sram_en`=1 is a read. A write happens in the same cycle when any `sram_we` bit is set.
- Read-first behaviour: `sram_rdata` on the next cycle is the word's content before this cycle's write.
- Byte-lane writes: only the lanes whose `sram_we` bit is set are updated. Other lanes keep their old value.
- `sram_we`=4'b0000 with `sram_en`=1 is a pure read.
- `sram_en`=0: no read and no write, whatever `sram_we` is. `sram_rdata` holds its previous value.
- Out-of-range access (`sram_en`=1 and not in range):
  - No write is performed.
  - Next `sram_rdata` = 32'h0000_0000.
  - `oor_err` is set.
  - `oor_cnt` increments by 1 and saturates at 16'hFFFF.
- `clr_err`=1: clears `oor_err` and `oor_cnt` on the next edge.
- `clr_err` in the same cycle as an out-of-range access: next `oor_err`=1 and next `oor_cnt`=1. The new event wins over the clear.
- Memory array contents are not reset and are undefined until written.
- Reset values:
  - `sram_rdata` = 0
  - `oor_err` = 0
  - `oor_cnt` = 0

## Timing
- Read latency is exactly 1 cycle: request at edge N, data valid after edge N+1 and held until the next enabled access.
- There is no stall or back-pressure. One access is accepted per cycle, with full throughput.
- Back-to-back write then read of the same word (cycles N, N+1): the read returns the written data.
- Read and write of the same word in one cycle returns the old data (read-first).
- Reset asserted mid-access: outputs go to their reset values immediately, asynchronously. A write in flight in that cycle is not guaranteed. After deassertion the first edge behaves normally.
- `oor_err` and `oor_cnt` update on the same edge as the offending access.

## Structure
- Shared package `sram_pkg`:
  - Default `BASE_ADDR` and `DEPTH_LOG2` constants.
  - An in-range function.
  - A byte-lane merge function: old word, wdata, we → new word.
- Natural sub-module: `sram_byte_bank`, an 8-bit wide, 2^DEPTH_LOG2 deep read-first bank with its own write enable.
  - Four instances, one per lane, share a single index.
  - The top level owns the range check, the output register, the zero-substitution for out-of-range reads and the error counter.

## Test plan
- Reset, then read offset 0: `sram_rdata` = 0 during reset. `oor_err` = 0 and `oor_cnt` = 0 after release.
- Write 32'h1234_5678 with we=4'hF at BASE+0x10, then read at BASE+0x10 on the next cycle → `sram_rdata` = 32'h1234_5678 one cycle after the read.
- Byte-lane write: over a stored 32'h1234_5678, write wdata=32'hAABB_CCDD with we=4'b0101 → read returns 32'h12BB_56DD.
- Read-first: read and write 32'hFFFF_FFFF to the same word in one cycle → next `sram_rdata` is the old value. A following read returns 32'hFFFF_FFFF.
- Out-of-range accesses:
  - Access BASE-4, then BASE+4*2^DEPTH_LOG2 with we=4'hF → both reads return 0.
  - `oor_cnt` = 2 and `oor_err` = 1.
  - No in-range word is modified.
  - `clr_err` together with a third out-of-range access → `oor_cnt` = 1.
- Hold and saturation:
  - `sram_en` = 0 for 5 cycles with `sram_we` toggling → `sram_rdata` is stable and memory is unchanged.
  - 65,540 out-of-range accesses → `oor_cnt` = 16'hFFFF.
